// File: rtl/jam_cost_arbiter_pkg.sv
// Shared geometry and types for the JAM cost-ROM arbiter: ROM shape, sum width, FSM states.
package jam_pkg;
  localparam int N_WORKERS = 8;
  localparam int JOB_W     = 3;
  localparam int COST_W    = 7;
  localparam int SUM_W     = 10;
  localparam int PERM_W    = N_WORKERS * JOB_W;

  // Element k holds the job index for worker k, matching bits [3k+2:3k] of a request.
  typedef logic [N_WORKERS-1:0][JOB_W-1:0] perm_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Requester-side bundle of the cost arbiter: per-requester request/permutation, grant and response.
interface jam_cost_arbiter_if #(
  parameter int NREQ = 2
);
  import jam_pkg::*;

  logic [NREQ-1:0]        req;
  logic [NREQ*PERM_W-1:0] req_perm;
  logic [NREQ-1:0]        gnt;
  logic                   rsp_valid;
  logic [2:0]             rsp_id;
  logic [SUM_W-1:0]       rsp_sum;

  modport master (
    output req, req_perm,
    input  gnt, rsp_valid, rsp_id, rsp_sum
  );

  modport slave (
    input  req, req_perm,
    output gnt, rsp_valid, rsp_id, rsp_sum
  );
endinterface

// File: rtl/jam_cost_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping to 0.
module jam_rr_picker #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      rr_ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [2:0]      win_idx,
  output logic            any
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  int cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(rr_ptr) + i) % NREQ;
      if (!any && req[cand[IDXW-1:0]]) begin
        any                     = 1'b1;
        win_idx                 = 3'(cand);
        win_oh[cand[IDXW-1:0]]  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jam_cost_arbiter.sv
// Shares one combinational cost ROM among NREQ evaluators; 8-beat read burst, response 9 edges after request.
// Optional JAM_ARB_STATS_EN adds a saturating burst_cnt output.
module jam_cost_arbiter
  import jam_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              CLK,
  input  logic              RST,
  jam_cost_arbiter_if.slave arb,
  output logic [JOB_W-1:0]  W,
  output logic [JOB_W-1:0]  J,
  input  logic [COST_W-1:0] Cost
`ifdef JAM_ARB_STATS_EN
  ,output logic [15:0]      burst_cnt
`endif
);
  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [2:0]        win_q, win_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        beat_q, beat_d;
  perm_t             perm_q, perm_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2:0]        rsp_id_q, rsp_id_d;
  logic [SUM_W-1:0]  rsp_sum_q, rsp_sum_d;

  logic [NREQ-1:0]   pick_oh;
  logic [2:0]        pick_idx;
  logic              pick_any;
  logic [PERM_W-1:0] perm_sel;

  jam_rr_picker #(.NREQ(NREQ)) u_picker (
    .req     (arb.req),
    .rr_ptr  (rr_ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    perm_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == 3'(i)) perm_sel = arb.req_perm[i*PERM_W +: PERM_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    win_d       = win_q;
    rr_ptr_d    = rr_ptr_q;
    beat_d      = beat_q;
    perm_d      = perm_q;
    acc_d       = acc_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          perm_d  = perm_t'(perm_sel);
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          acc_d   = '0;
          beat_d  = '0;
          state_d = READ;
        end
      end
      READ: begin
        acc_d  = acc_q + SUM_W'(Cost);
        beat_d = beat_q + 3'd1;
        // The last beat's cost goes straight into the response so DONE carries the full sum.
        if (beat_q == 3'(N_WORKERS - 1)) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_id_d    = win_q;
          rsp_sum_d   = acc_d;
        end
      end
      DONE: begin
        rr_ptr_d = (int'(win_q) + 1 == NREQ) ? 3'd0 : win_q + 3'd1;
        gnt_d    = '0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      win_q       <= '0;
      rr_ptr_q    <= '0;
      beat_q      <= '0;
      perm_q      <= '0;
      acc_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      win_q       <= win_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_q      <= beat_d;
      perm_q      <= perm_d;
      acc_q       <= acc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  assign W             = (state_q == READ) ? beat_q : '0;
  assign J             = (state_q == READ) ? perm_q[beat_q] : '0;
  assign arb.gnt       = gnt_q;
  assign arb.rsp_valid = rsp_valid_q;
  assign arb.rsp_id    = rsp_id_q;
  assign arb.rsp_sum   = rsp_sum_q;

`ifdef JAM_ARB_STATS_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == DONE && burst_cnt_q != 16'hFFFF) burst_cnt_d = burst_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) burst_cnt_q <= '0;
    else      burst_cnt_q <= burst_cnt_d;
  end

  assign burst_cnt = burst_cnt_q;
`endif
endmodule
